nanomamba_wt_arbiter: RTL and testbench

Round-robin arbiter that shares the single-port weight SRAM (8-bit, 13-bit address) between NanoMamba requesters: frontend, SSM and classifier. It grants one read per cycle and drives the SRAM port. It returns each read datum to the requester that issued it, tagged by requester, with fixed latency. Optional bus lock lets a requester (e.g. the classifier's 192-MAC sweep) hold the port for back-to-back reads, bounded by a timeout.

---
 rtl/nanomamba_wt_arbiter.sv | 153 +++++++++++++++
 tb/tb_nanomamba_wt_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/nanomamba_wt_arbiter.sv
// Round-robin arbiter for the shared single-port weight SRAM, with optional bounded bus lock.
// Combinational grant; each read returns to the requester that issued it exactly 2 cycles after accept.
module nanomamba_wt_arbiter #(
  parameter int N_REQ      = 3,
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int SRAM_DEPTH = 2860,
  parameter int LOCK_MAX   = 255
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ-1:0]            req_lock,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        rsp_err,
  output logic                        sram_rd_en,
  output logic [ADDR_WIDTH-1:0]       sram_addr,
  input  logic [DATA_WIDTH-1:0]       sram_rdata,
  output logic                        lock_owner_valid,
  output logic                        lock_timeout
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  logic [PTR_W-1:0]      rr_ptr, rr_ptr_nxt;
  logic                  lock_vld, lock_vld_nxt;
  logic [PTR_W-1:0]      lock_owner, lock_owner_nxt;
  logic [CNT_W-1:0]      lock_cnt, lock_cnt_nxt, cnt_inc;
  logic                  timeout_nxt;

  logic                  s1_vld, s1_err, s2_vld, s2_err;
  logic [PTR_W-1:0]      s1_idx, s2_idx;

  logic                  acc, acc_err, acc_lock;
  logic [PTR_W-1:0]      acc_idx, cand;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [ADDR_WIDTH-1:0] addr_arr [N_REQ];
  int                    j;

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + PTR_W'(1);
  endfunction

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // While locked only the owner may win, even when it is idle.
  always_comb begin
    gnt     = '0;
    acc     = 1'b0;
    acc_idx = '0;
    cand    = '0;
    j       = 0;
    if (lock_vld) begin
      if (req[lock_owner]) begin
        gnt[lock_owner] = 1'b1;
        acc             = 1'b1;
        acc_idx         = lock_owner;
      end
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        j = int'(rr_ptr) + k;
        if (j >= N_REQ) j = j - N_REQ;
        cand = PTR_W'(j);
        if (!acc && req[cand]) begin
          gnt[cand] = 1'b1;
          acc       = 1'b1;
          acc_idx   = cand;
        end
      end
    end
  end

  assign acc_addr = addr_arr[acc_idx];
  assign acc_err  = int'(acc_addr) >= SRAM_DEPTH;
  assign acc_lock = req_lock[acc_idx];

  // The acquiring accept counts toward LOCK_MAX; rr_ptr only moves on unlocked accepts and releases.
  always_comb begin
    rr_ptr_nxt     = rr_ptr;
    lock_vld_nxt   = lock_vld;
    lock_owner_nxt = lock_owner;
    lock_cnt_nxt   = lock_cnt;
    timeout_nxt    = 1'b0;
    cnt_inc        = (lock_vld ? lock_cnt : '0) + CNT_W'(1);
    if (acc) begin
      if (acc_lock && cnt_inc != CNT_W'(LOCK_MAX)) begin
        lock_vld_nxt   = 1'b1;
        lock_owner_nxt = acc_idx;
        lock_cnt_nxt   = cnt_inc;
      end else begin
        timeout_nxt  = acc_lock;
        lock_vld_nxt = 1'b0;
        lock_cnt_nxt = '0;
        rr_ptr_nxt   = ptr_after(acc_idx);
      end
    end else if (lock_vld && !req_lock[lock_owner]) begin
      lock_vld_nxt = 1'b0;
      lock_cnt_nxt = '0;
      rr_ptr_nxt   = ptr_after(lock_owner);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      lock_vld     <= 1'b0;
      lock_owner   <= '0;
      lock_cnt     <= '0;
      lock_timeout <= 1'b0;
      sram_rd_en   <= 1'b0;
      sram_addr    <= '0;
      s1_vld       <= 1'b0;
      s1_err       <= 1'b0;
      s1_idx       <= '0;
      s2_vld       <= 1'b0;
      s2_err       <= 1'b0;
      s2_idx       <= '0;
    end else begin
      rr_ptr       <= rr_ptr_nxt;
      lock_vld     <= lock_vld_nxt;
      lock_owner   <= lock_owner_nxt;
      lock_cnt     <= lock_cnt_nxt;
      lock_timeout <= timeout_nxt;
      sram_rd_en   <= acc && !acc_err;
      if (acc) sram_addr <= acc_addr;
      s1_vld       <= acc;
      s1_err       <= acc_err;
      s1_idx       <= acc_idx;
      s2_vld       <= s1_vld;
      s2_err       <= s1_err;
      s2_idx       <= s1_idx;
    end
  end

  // Out-of-range slots never enabled the SRAM, so its stale output is masked.
  always_comb begin
    rsp_valid = '0;
    if (s2_vld) rsp_valid[s2_idx] = 1'b1;
  end

  assign rsp_err          = s2_vld && s2_err;
  assign rsp_data         = (s2_vld && !s2_err) ? sram_rdata : '0;
  assign lock_owner_valid = lock_vld;

endmodule

// File: tb/tb_nanomamba_wt_arbiter.sv
// Directed bench for nanomamba_wt_arbiter (LOCK_MAX=4) with a behavioural SRAM returning addr[7:0]^addr[12:8].
module tb_nanomamba_wt_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  req_lock = '0;
  logic [12:0] a0 = '0, a1 = '0, a2 = '0;
  logic [38:0] req_addr;
  logic [2:0]  gnt;
  logic [2:0]  rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic        sram_rd_en;
  logic [12:0] sram_addr;
  logic [7:0]  sram_rdata = 8'h00;
  logic        lock_owner_valid;
  logic        lock_timeout;

  int checks = 0;
  int failures = 0;

  localparam logic [7:0] GNT_TBL [8] = '{8'd1, 8'd2, 8'd4, 8'd1, 8'd2, 8'd4, 8'd0, 8'd0};
  localparam logic [7:0] RSP_TBL [8] = '{8'd0, 8'd0, 8'd1, 8'd2, 8'd4, 8'd1, 8'd2, 8'd4};
  localparam logic [7:0] DAT_TBL [8] = '{8'h00, 8'h00, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30};

  assign req_addr = {a2, a1, a0};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_rd_en) sram_rdata <= sram_addr[7:0] ^ {3'b000, sram_addr[12:8]};
  end

  nanomamba_wt_arbiter #(
    .N_REQ(3), .ADDR_WIDTH(13), .DATA_WIDTH(8), .SRAM_DEPTH(2860), .LOCK_MAX(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_lock(req_lock), .req_addr(req_addr),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .sram_rd_en(sram_rd_en), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .lock_owner_valid(lock_owner_valid), .lock_timeout(lock_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks happen 3 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_regs(input string tag);
    chk({tag, "_rd_en"}, 32'(sram_rd_en), 0);
    chk({tag, "_addr"}, 32'(sram_addr), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_lock_vld"}, 32'(lock_owner_valid), 0);
    chk({tag, "_timeout"}, 32'(lock_timeout), 0);
  endtask

  initial begin
    #3;
    chk_idle_regs("reset");
    chk("reset_gnt", 32'(gnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester
    next_cycle();
    req = 3'b010; a1 = 13'h0A50;
    #3 chk("single_gnt", 32'(gnt), 32'h2);
    next_cycle();
    req = 3'b000;
    #3 chk("single_rd_en", 32'(sram_rd_en), 1);
    chk("single_addr", 32'(sram_addr), 32'h0A50);
    chk("single_no_rsp_early", 32'(rsp_valid), 0);
    next_cycle();
    #3 chk("single_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("single_rsp_data", 32'(rsp_data), 32'h5A);
    chk("single_rsp_err", 32'(rsp_err), 0);
    chk("single_rd_en_idle", 32'(sram_rd_en), 0);
    next_cycle();
    #3 chk("single_rsp_gone", 32'(rsp_valid), 0);

    // Contention from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    a0 = 13'h0010; a1 = 13'h0121; a2 = 13'h0232;
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      req = (k < 6) ? 3'b111 : 3'b000;
      #3 chk($sformatf("rr_gnt_%0d", k), 32'(gnt), 32'(GNT_TBL[k]));
      chk($sformatf("rr_rsp_%0d", k), 32'(rsp_valid), 32'(RSP_TBL[k]));
      if (k >= 2) chk($sformatf("rr_data_%0d", k), 32'(rsp_data), 32'(DAT_TBL[k]));
    end

    // Lock by requester 2 with requester 0 competing
    next_cycle();
    req = 3'b100; req_lock = 3'b100; a2 = 13'h0300;
    #3 chk("lock_acq_gnt", 32'(gnt), 32'h4);
    chk("lock_acq_vld_before", 32'(lock_owner_valid), 0);
    next_cycle();
    req = 3'b001;
    #3 chk("lock_idle_owner_gnt", 32'(gnt), 0);
    chk("lock_held", 32'(lock_owner_valid), 1);
    next_cycle();
    req = 3'b101;
    #3 chk("lock_gnt_2", 32'(gnt), 32'h4);
    next_cycle();
    #3 chk("lock_gnt_3", 32'(gnt), 32'h4);
    next_cycle();
    req_lock = 3'b000;
    #3 chk("lock_gnt_4_release", 32'(gnt), 32'h4);
    next_cycle();
    req = 3'b001;
    #3 chk("lock_after_gnt", 32'(gnt), 32'h1);
    chk("lock_after_vld", 32'(lock_owner_valid), 0);
    chk("lock_after_timeout", 32'(lock_timeout), 0);
    next_cycle();
    req = 3'b000;

    // Timeout: requester 1 owns, requester 0 waits
    next_cycle();
    req = 3'b011; req_lock = 3'b011; a0 = 13'h0005; a1 = 13'h0106;
    #3 chk("to_gnt_0", 32'(gnt), 32'h2);
    for (int k = 1; k < 4; k++) begin
      next_cycle();
      #3 chk($sformatf("to_gnt_%0d", k), 32'(gnt), 32'h2);
      chk($sformatf("to_lock_%0d", k), 32'(lock_owner_valid), 1);
      chk($sformatf("to_pulse_%0d", k), 32'(lock_timeout), 0);
    end
    next_cycle();
    req_lock = 3'b000;
    #3 chk("to_pulse", 32'(lock_timeout), 1);
    chk("to_released", 32'(lock_owner_valid), 0);
    chk("to_next_gnt", 32'(gnt), 32'h1);
    next_cycle();
    req = 3'b000;
    #3 chk("to_pulse_end", 32'(lock_timeout), 0);

    // Out of range
    next_cycle();
    req = 3'b001; a0 = 13'h1FFF;
    #3 chk("oor_gnt", 32'(gnt), 32'h1);
    next_cycle();
    req = 3'b000;
    #3 chk("oor_rd_en", 32'(sram_rd_en), 0);
    chk("oor_no_rsp_early", 32'(rsp_valid), 0);
    next_cycle();
    #3 chk("oor_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("oor_rsp_err", 32'(rsp_err), 1);
    chk("oor_rsp_data", 32'(rsp_data), 0);

    // Reset with reads in flight
    a0 = 13'h0005; a1 = 13'h0106;
    next_cycle();
    req = 3'b011;
    #3 chk("mid_gnt_a", 32'(gnt), 32'h2);
    next_cycle();
    #3 chk("mid_gnt_b", 32'(gnt), 32'h1);
    next_cycle();
    req = 3'b000;
    #1 chk("mid_inflight_rd_en", 32'(sram_rd_en), 1);
    chk("mid_inflight_rsp", 32'(rsp_valid), 32'h2);
    rst_n = 1'b0;
    #1 chk_idle_regs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    next_cycle();
    #3 chk("post_reset_rsp_a", 32'(rsp_valid), 0);
    next_cycle();
    #3 chk("post_reset_rsp_b", 32'(rsp_valid), 0);
    next_cycle();
    req = 3'b111;
    #3 chk("post_reset_gnt", 32'(gnt), 32'h1);
    next_cycle();
    req = 3'b000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
